// File: rtl/trap_sequencer_if.sv
// Interrupt/exception request inputs plus the CSR port and PC-load path
// shared by the trap sequencer and the main control FSM.
interface trap_sequencer_if #(
  parameter int NUM_IRQ = 4
);
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_en;
  logic               mie;
  logic               boundary;
  logic               exc_req;
  logic [4:0]         exc_code;
  logic [31:0]        pc;
  logic [31:0]        csr_rdata;
  logic               trap_req;
  logic               trap_active;
  logic               csr_we;
  logic [11:0]        csr_addr;
  logic [31:0]        csr_wdata;
  logic               pc_load;
  logic [31:0]        pc_next;
  logic               mie_reset;

  modport master (
    input  irq, irq_en, mie, boundary, exc_req, exc_code, pc, csr_rdata,
    output trap_req, trap_active, csr_we, csr_addr, csr_wdata, pc_load,
           pc_next, mie_reset
  );

  modport slave (
    output irq, irq_en, mie, boundary, exc_req, exc_code, pc, csr_rdata,
    input  trap_req, trap_active, csr_we, csr_addr, csr_wdata, pc_load,
           pc_next, mie_reset
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap-entry sequencer: arbitrates interrupts and a synchronous exception at
// instruction boundaries, then writes mepc, mcause and loads the trap vector.
module trap_sequencer #(
  parameter int                 NUM_IRQ   = 4,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}},
  parameter bit                 VECTORED  = 1'b1
) (
  input logic              clk,
  input logic              reset_n,
  trap_sequencer_if.master bus
);

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SAVE_EPC   = 2'd1,
    SAVE_CAUSE = 2'd2,
    LOAD_VEC   = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [NUM_IRQ-1:0] irq_q_r;
  logic [NUM_IRQ-1:0] edge_pend_r;
  logic [NUM_IRQ-1:0] edge_pend_s;
  logic [31:0]        epc_r;
  logic               intr_r;
  logic [4:0]         code_r;

  logic [NUM_IRQ-1:0] pend_s;
  logic [NUM_IRQ-1:0] elig_s;
  logic [NUM_IRQ-1:0] win_s;
  logic [4:0]         win_code_s;
  logic               found_s;
  logic               irq_fire_s;
  logic               accept_s;
  logic [31:0]        base_s;
  logic               vec_mode_s;

  // Pending/eligible vectors, lowest-index winner and accept decision
  always_comb begin
    pend_s     = (EDGE_MASK & edge_pend_r) | (~EDGE_MASK & bus.irq);
    elig_s     = pend_s & bus.irq_en;
    win_s      = {NUM_IRQ{1'b0}};
    win_code_s = 5'd0;
    found_s    = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig_s[i] && !found_s) begin
        found_s    = 1'b1;
        win_s[i]   = 1'b1;
        win_code_s = (i == 0) ? 5'd7 : 5'(15 + i);
      end else begin
        win_s[i]   = 1'b0;
      end
    end
    irq_fire_s = bus.mie & found_s;
    accept_s   = (state_r == IDLE) & bus.boundary & (bus.exc_req | irq_fire_s);
    // A new edge in the accept cycle must survive the clear of the taken line
    if (accept_s && !bus.exc_req) begin
      edge_pend_s = ((edge_pend_r & ~win_s) | (bus.irq & ~irq_q_r)) & EDGE_MASK;
    end else begin
      edge_pend_s = (edge_pend_r | (bus.irq & ~irq_q_r)) & EDGE_MASK;
    end
  end

  assign bus.trap_req = accept_s;
  assign base_s       = {bus.csr_rdata[31:2], 2'b00};
  assign vec_mode_s   = VECTORED && intr_r && (bus.csr_rdata[1:0] == 2'b01);

  // Next-state and per-state CSR / PC-load outputs
  always_comb begin
    state_s         = state_r;
    bus.trap_active = 1'b0;
    bus.csr_we      = 1'b0;
    bus.csr_addr    = 12'h000;
    bus.csr_wdata   = 32'h0000_0000;
    bus.pc_load     = 1'b0;
    bus.pc_next     = 32'h0000_0000;
    bus.mie_reset   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SAVE_EPC;
        end else begin
          state_s = IDLE;
        end
      end
      SAVE_EPC: begin
        bus.trap_active = 1'b1;
        bus.csr_we      = 1'b1;
        bus.csr_addr    = CSR_MEPC;
        bus.csr_wdata   = epc_r;
        bus.mie_reset   = 1'b1;
        state_s         = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        bus.trap_active = 1'b1;
        bus.csr_we      = 1'b1;
        bus.csr_addr    = CSR_MCAUSE;
        bus.csr_wdata   = {intr_r, 26'd0, code_r};
        state_s         = LOAD_VEC;
      end
      LOAD_VEC: begin
        bus.trap_active = 1'b1;
        bus.csr_addr    = CSR_MTVEC;
        bus.pc_load     = 1'b1;
        if (vec_mode_s) begin
          bus.pc_next = base_s + {25'd0, code_r, 2'b00};
        end else begin
          bus.pc_next = base_s;
        end
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, edge tracking and captured trap context
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      irq_q_r     <= {NUM_IRQ{1'b0}};
      edge_pend_r <= {NUM_IRQ{1'b0}};
      epc_r       <= 32'h0000_0000;
      intr_r      <= 1'b0;
      code_r      <= 5'd0;
    end else begin
      state_r     <= state_s;
      irq_q_r     <= bus.irq;
      edge_pend_r <= edge_pend_s;
      if (accept_s) begin
        epc_r  <= bus.pc;
        intr_r <= ~bus.exc_req;
        code_r <= bus.exc_req ? bus.exc_code : win_code_s;
      end else begin
        epc_r  <= epc_r;
        intr_r <= intr_r;
        code_r <= code_r;
      end
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed vector bench for trap_sequencer: a level/edge-on-line-1 instance
// and an edge-on-line-0 instance sharing the same input stimulus.
module tb_trap_sequencer;

  typedef struct packed {
    logic [3:0]  irq;
    logic [3:0]  irq_en;
    logic        mie;
    logic        boundary;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] pc;
    logic [31:0] csr_rdata;
  } in_t;

  typedef struct packed {
    logic        trap_req;
    logic        trap_active;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        mie_reset;
  } out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sel_b = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  trap_sequencer_if #(.NUM_IRQ(4)) aif ();
  trap_sequencer_if #(.NUM_IRQ(4)) bif ();

  trap_sequencer #(.NUM_IRQ(4), .EDGE_MASK(4'b0010), .VECTORED(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(aif.master));
  trap_sequencer #(.NUM_IRQ(4), .EDGE_MASK(4'b0001), .VECTORED(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bif.master));

  assign bif.irq       = aif.irq;
  assign bif.irq_en    = aif.irq_en;
  assign bif.mie       = aif.mie;
  assign bif.boundary  = aif.boundary;
  assign bif.exc_req   = aif.exc_req;
  assign bif.exc_code  = aif.exc_code;
  assign bif.pc        = aif.pc;
  assign bif.csr_rdata = aif.csr_rdata;

  out_t act_a, act_b, act;
  assign act_a = {aif.trap_req, aif.trap_active, aif.csr_we, aif.csr_addr,
                  aif.csr_wdata, aif.pc_load, aif.pc_next, aif.mie_reset};
  assign act_b = {bif.trap_req, bif.trap_active, bif.csr_we, bif.csr_addr,
                  bif.csr_wdata, bif.pc_load, bif.pc_next, bif.mie_reset};
  assign act   = sel_b ? act_b : act_a;

  always #5 clk = ~clk;

  function automatic in_t mk_in(logic [3:0] irq, logic [3:0] en, logic mie,
                                logic bnd, logic exc, logic [4:0] code,
                                logic [31:0] pc, logic [31:0] rdata);
    in_t v;
    v.irq = irq; v.irq_en = en; v.mie = mie; v.boundary = bnd;
    v.exc_req = exc; v.exc_code = code; v.pc = pc; v.csr_rdata = rdata;
    return v;
  endfunction

  function automatic out_t o_none();
    out_t o;
    o = '0;
    return o;
  endfunction

  function automatic out_t o_req();
    out_t o;
    o = '0; o.trap_req = 1'b1;
    return o;
  endfunction

  function automatic out_t o_epc(logic [31:0] pc);
    out_t o;
    o = '0; o.trap_active = 1'b1; o.csr_we = 1'b1; o.csr_addr = 12'h341;
    o.csr_wdata = pc; o.mie_reset = 1'b1;
    return o;
  endfunction

  function automatic out_t o_cause(logic [31:0] mc);
    out_t o;
    o = '0; o.trap_active = 1'b1; o.csr_we = 1'b1; o.csr_addr = 12'h342;
    o.csr_wdata = mc;
    return o;
  endfunction

  function automatic out_t o_vec(logic [31:0] pn);
    out_t o;
    o = '0; o.trap_active = 1'b1; o.csr_addr = 12'h305; o.pc_load = 1'b1;
    o.pc_next = pn;
    return o;
  endfunction

  task automatic apply(input in_t v);
    aif.irq = v.irq; aif.irq_en = v.irq_en; aif.mie = v.mie;
    aif.boundary = v.boundary; aif.exc_req = v.exc_req;
    aif.exc_code = v.exc_code; aif.pc = v.pc; aif.csr_rdata = v.csr_rdata;
  endtask

  task automatic check(input string name, input out_t e);
    n_vec++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic step(input string name, input in_t v, input out_t e);
    @(negedge clk);
    apply(v);
    #1;
    check(name, e);
  endtask

  vec_t tbl[$];
  in_t  q;

  initial begin
    // level line 0, direct mtvec
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h100, 32'h200), o_req()});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h100, 32'h200), o_epc(32'h100)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h100, 32'h200), o_cause(32'h8000_0007)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h100, 32'h200), o_vec(32'h200)});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h104, 32'h200), o_none()});
    // gating: no boundary, line disabled, global mie low
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h104, 32'h200), o_none()});
    tbl.push_back({mk_in(4'h1, 4'hE, 1'b1, 1'b1, 1'b0, 5'd0, 32'h104, 32'h200), o_none()});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h104, 32'h200), o_none()});
    // lines 2 and 3, vectored mtvec 0x401
    tbl.push_back({mk_in(4'hC, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h300, 32'h401), o_req()});
    tbl.push_back({mk_in(4'hC, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h300, 32'h401), o_epc(32'h300)});
    tbl.push_back({mk_in(4'hC, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h300, 32'h401), o_cause(32'h8000_0011)});
    tbl.push_back({mk_in(4'hC, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h300, 32'h401), o_vec(32'h444)});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h304, 32'h401), o_none()});
    // exception beats interrupt; interrupt follows at next boundary
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b1, 5'd11, 32'h500, 32'h401), o_req()});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h500, 32'h401), o_epc(32'h500)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h500, 32'h401), o_cause(32'h0000_000B)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h500, 32'h401), o_vec(32'h400)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h600, 32'h401), o_req()});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h600, 32'h401), o_epc(32'h600)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h600, 32'h401), o_cause(32'h8000_0007)});
    tbl.push_back({mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h600, 32'h401), o_vec(32'h41C)});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h604, 32'h401), o_none()});
    // exception ignores mie
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b0, 1'b1, 1'b1, 5'd2, 32'h700, 32'h200), o_req()});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h700, 32'h200), o_epc(32'h700)});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h700, 32'h200), o_cause(32'h0000_0002)});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h700, 32'h200), o_vec(32'h200)});
    tbl.push_back({mk_in(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h704, 32'h200), o_none()});

    apply(mk_in(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", o_none());
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end

    // edge line 1 pulsed while mie=0, taken once mie rises
    step("edge_pulse", mk_in(4'h2, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h800, 32'h200), o_none());
    for (int i = 0; i < 10; i++) begin
      step($sformatf("edge_wait%0d", i),
           mk_in(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 5'd0, 32'h800, 32'h200), o_none());
    end
    q = mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h800, 32'h200);
    step("edge_req", q, o_req());
    step("edge_epc", q, o_epc(32'h800));
    step("edge_cause", q, o_cause(32'h8000_0010));
    step("edge_vec", q, o_vec(32'h200));
    for (int i = 0; i < 4; i++) begin
      step($sformatf("edge_nosecond%0d", i), q, o_none());
    end

    // async reset in SAVE_CAUSE, then a clean trap
    step("rst_req", mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 5'd3, 32'h900, 32'h200), o_req());
    q = mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'h900, 32'h200);
    step("rst_epc", q, o_epc(32'h900));
    step("rst_cause", q, o_cause(32'h0000_0003));
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_zero", o_none());
    step("rst_hold0", q, o_none());
    step("rst_hold1", q, o_none());
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_release", o_none());
    step("rst_new_req", mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b1, 5'd2, 32'hA00, 32'h200), o_req());
    q = mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'hA00, 32'h200);
    step("rst_new_epc", q, o_epc(32'hA00));
    step("rst_new_cause", q, o_cause(32'h0000_0002));
    step("rst_new_vec", q, o_vec(32'h200));
    step("rst_new_idle", q, o_none());

    // edge line 0 (second instance): new edge in its own accept cycle
    @(negedge clk);
    reset_n = 1'b0;
    apply(mk_in(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 5'd0, 32'hB00, 32'h200));
    @(negedge clk);
    reset_n = 1'b1;
    sel_b = 1'b1;
    step("e0_first_edge", mk_in(4'h1, 4'hF, 1'b1, 1'b0, 1'b0, 5'd0, 32'hB00, 32'h200), o_none());
    step("e0_low", mk_in(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 5'd0, 32'hB00, 32'h200), o_none());
    step("e0_req", mk_in(4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'hB00, 32'h200), o_req());
    q = mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'hB00, 32'h200);
    step("e0_epc", q, o_epc(32'hB00));
    step("e0_cause", q, o_cause(32'h8000_0007));
    step("e0_vec", q, o_vec(32'h200));
    q = mk_in(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 32'hB04, 32'h200);
    step("e0_req2", q, o_req());
    step("e0_epc2", q, o_epc(32'hB04));
    step("e0_cause2", q, o_cause(32'h8000_0007));
    step("e0_vec2", q, o_vec(32'h200));
    step("e0_idle0", q, o_none());
    step("e0_idle1", q, o_none());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
